// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings, default md latencies and the RAW hazard compare for pipe_hazard_ctrl.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W        = 4;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic pc_sel_exc;
    logic pc_sel_epc;
  } ctrl_t;

  // TUSE_NONE (3) can never be below a 2-bit tnew, so unused operands never hit.
  function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy: loadable down-counter that saturates at zero, plus the busy flag.
module md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  input  logic load_kill,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] md_cnt_q;
  logic [MD_CNT_W-1:0] md_cnt_d;

  // A new start reloads even while counting; there is no queueing of ops.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start && !load_kill) begin
      md_cnt_d = md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = md_start || (md_cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW, mult/div and eret hazards,
// exception/eret redirects and a free-running stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [1:0]  tuse_rs_d,
  input  logic [1:0]  tuse_rt_d,
  input  logic [4:0]  a3_e,
  input  logic [4:0]  a3_m,
  input  logic [1:0]  tnew_e,
  input  logic [1:0]  tnew_m,
  input  logic        md_start_e,
  input  logic        md_div_e,
  input  logic        md_use_d,
  input  logic        mtc0_epc_e,
  input  logic        mtc0_epc_m,
  input  logic        eret_d,
  input  logic        exc_m,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        pc_sel_exc,
  output logic        pc_sel_epc,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic        data_haz;
  logic        md_haz;
  logic        eret_haz;
  logic        stall;
  ctrl_t       ctrl;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start_e),
    .md_div    (md_div_e),
    .load_kill (exc_m),
    .md_busy   (md_busy)
  );

  always_comb begin
    data_haz = raw_hit(rs_d, tuse_rs_d, a3_e, tnew_e)
            || raw_hit(rs_d, tuse_rs_d, a3_m, tnew_m)
            || raw_hit(rt_d, tuse_rt_d, a3_e, tnew_e)
            || raw_hit(rt_d, tuse_rt_d, a3_m, tnew_m);
    md_haz   = md_use_d && md_busy;
    eret_haz = eret_d && (mtc0_epc_e || mtc0_epc_m);
    stall    = data_haz || md_haz || eret_haz;
  end

  // Flushes are only raised when not frozen: a held pipeline register ignores clear.
  always_comb begin
    ctrl = '0;
    if (exc_m) begin
      ctrl.flush_d    = 1'b1;
      ctrl.flush_e    = 1'b1;
      ctrl.flush_m    = 1'b1;
      ctrl.pc_sel_exc = 1'b1;
    end else if (stall) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (eret_d) begin
      // eret has no delay slot, so the already-fetched successor is squashed.
      ctrl.pc_sel_epc = 1'b1;
      ctrl.flush_d    = 1'b1;
    end
  end

  assign stall_f    = ctrl.stall_f;
  assign stall_d    = ctrl.stall_d;
  assign flush_d    = ctrl.flush_d;
  assign flush_e    = ctrl.flush_e;
  assign flush_m    = ctrl.flush_m;
  assign pc_sel_exc = ctrl.pc_sel_exc;
  assign pc_sel_epc = ctrl.pc_sel_epc;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.stall_d) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the combinational hazard/priority
// logic plus hand-written multi-cycle sequences for md occupancy, reset and counter wrap.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_d, rt_d, a3_e, a3_m;
  logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic        md_start_e, md_div_e, md_use_d;
  logic        mtc0_epc_e, mtc0_epc_m, eret_d, exc_m;
  logic        stall_f, stall_d, flush_d, flush_e, flush_m;
  logic        pc_sel_exc, pc_sel_epc, md_busy;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .tuse_rs_d  (tuse_rs_d),
    .tuse_rt_d  (tuse_rt_d),
    .a3_e       (a3_e),
    .a3_m       (a3_m),
    .tnew_e     (tnew_e),
    .tnew_m     (tnew_m),
    .md_start_e (md_start_e),
    .md_div_e   (md_div_e),
    .md_use_d   (md_use_d),
    .mtc0_epc_e (mtc0_epc_e),
    .mtc0_epc_m (mtc0_epc_m),
    .eret_d     (eret_d),
    .exc_m      (exc_m),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .pc_sel_exc (pc_sel_exc),
    .pc_sel_epc (pc_sel_epc),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, a3e, a3m;
    logic [1:0] urs, urt, ne, nm;
    logic       mduse, mte, mtm, eret, exc;
    logic [6:0] exp_ctrl;   // {stall_f, stall_d, flush_d, flush_e, flush_m, pc_sel_exc, pc_sel_epc}
  } vec_t;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1101000;
  localparam logic [6:0] C_EXC   = 7'b0011110;
  localparam logic [6:0] C_ERET  = 7'b0010001;

  vec_t vecs[$];

  function automatic logic [6:0] ctrl_now();
    return {stall_f, stall_d, flush_d, flush_e, flush_m, pc_sel_exc, pc_sel_epc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs_d = '0; rt_d = '0; a3_e = '0; a3_m = '0;
    tuse_rs_d = TUSE_NONE; tuse_rt_d = TUSE_NONE; tnew_e = '0; tnew_m = '0;
    md_start_e = 0; md_div_e = 0; md_use_d = 0;
    mtc0_epc_e = 0; mtc0_epc_m = 0; eret_d = 0; exc_m = 0;
  endtask

  task automatic add(input string n, input logic [4:0] rs, input logic [1:0] urs,
                     input logic [4:0] rt, input logic [1:0] urt,
                     input logic [4:0] a3e, input logic [1:0] ne,
                     input logic [4:0] a3m, input logic [1:0] nm,
                     input logic mduse, input logic mte, input logic mtm,
                     input logic eret, input logic exc, input logic [6:0] ec);
    vec_t v;
    v.name = n; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.a3e = a3e; v.ne = ne; v.a3m = a3m; v.nm = nm;
    v.mduse = mduse; v.mte = mte; v.mtm = mtm; v.eret = eret; v.exc = exc;
    v.exp_ctrl = ec;
    vecs.push_back(v);
  endtask

  // md sequence: issue at cycle t with md_use_d held, expect stall through t+busy_len-1.
  task automatic md_seq(input string n, input logic is_div, input int busy_len);
    md_start_e = 1; md_div_e = is_div; md_use_d = 1;
    for (int c = 0; c <= busy_len; c++) begin
      @(negedge clk);
      check($sformatf("%s_busy_c%0d", n, c), {31'd0, md_busy}, {31'd0, c < busy_len});
      check($sformatf("%s_stall_c%0d", n, c), {25'd0, ctrl_now()},
            {25'd0, (c < busy_len) ? C_STALL : C_NONE});
      if (c < busy_len) exp_cnt++;
      @(posedge clk); #1;
      md_start_e = 0;
    end
    check({n, "_stall_cnt"}, stall_cnt, exp_cnt);
    md_use_d = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_cnt = 0;
    @(negedge clk);
    check("reset_ctrl", {25'd0, ctrl_now()}, {25'd0, C_NONE});
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_cnt", stall_cnt, 32'd0);

    //   name            rs urs rt urt a3e ne a3m nm mdu mte mtm eret exc exp
    add("all_zero",      0, 3,  0, 3,  0,  0, 0,  0, 0,  0,  0,  0,   0,  C_NONE);
    add("load_use",      5, 1,  0, 3,  5,  2, 0,  0, 0,  0,  0,  0,   0,  C_STALL);
    add("load_use_r0",   0, 1,  0, 3,  5,  2, 0,  0, 0,  0,  0,  0,   0,  C_NONE);
    add("r0_matches_r0", 0, 0,  0, 0,  0,  3, 0,  3, 0,  0,  0,  0,   0,  C_NONE);
    add("rt_vs_m",       0, 3,  7, 0,  0,  0, 7,  1, 0,  0,  0,  0,   0,  C_STALL);
    add("rt_m_ready",    0, 3,  7, 1,  0,  0, 7,  1, 0,  0,  0,  0,   0,  C_NONE);
    add("rs_vs_m",      12, 0,  0, 3,  0,  0,12,  1, 0,  0,  0,  0,   0,  C_STALL);
    add("tuse_none",     9, 3,  9, 3,  9,  3, 9,  3, 0,  0,  0,  0,   0,  C_NONE);
    add("tuse2_tnew3",   9, 2,  0, 3,  9,  3, 0,  0, 0,  0,  0,  0,   0,  C_STALL);
    add("diff_reg",      4, 0,  6, 0,  5,  3, 7,  3, 0,  0,  0,  0,   0,  C_NONE);
    add("exc_over_haz",  5, 1,  0, 3,  5,  2, 0,  0, 0,  0,  0,  0,   1,  C_EXC);
    add("eret_mtc0_e",   0, 3,  0, 3,  0,  0, 0,  0, 0,  1,  0,  1,   0,  C_STALL);
    add("eret_mtc0_m",   0, 3,  0, 3,  0,  0, 0,  0, 0,  0,  1,  1,   0,  C_STALL);
    add("eret_clear",    0, 3,  0, 3,  0,  0, 0,  0, 0,  0,  0,  1,   0,  C_ERET);
    add("eret_exc",      0, 3,  0, 3,  0,  0, 0,  0, 0,  1,  0,  1,   1,  C_EXC);
    add("mduse_idle",    0, 3,  0, 3,  0,  0, 0,  0, 1,  0,  0,  0,   0,  C_NONE);
    add("mtc0_no_eret",  0, 3,  0, 3,  0,  0, 0,  0, 0,  1,  1,  0,   0,  C_NONE);

    foreach (vecs[i]) begin
      rs_d = vecs[i].rs; tuse_rs_d = vecs[i].urs;
      rt_d = vecs[i].rt; tuse_rt_d = vecs[i].urt;
      a3_e = vecs[i].a3e; tnew_e = vecs[i].ne;
      a3_m = vecs[i].a3m; tnew_m = vecs[i].nm;
      md_use_d = vecs[i].mduse; mtc0_epc_e = vecs[i].mte; mtc0_epc_m = vecs[i].mtm;
      eret_d = vecs[i].eret; exc_m = vecs[i].exc;
      @(negedge clk);
      check({vecs[i].name, "_ctrl"}, {25'd0, ctrl_now()}, {25'd0, vecs[i].exp_ctrl});
      if (vecs[i].exp_ctrl[5]) exp_cnt++;
      @(posedge clk); #1;
      check({vecs[i].name, "_cnt"}, stall_cnt, exp_cnt);
    end
    idle_inputs();

    md_seq("div", 1'b1, 11);
    md_seq("mult", 1'b0, 6);

    // Exception in the issue cycle suppresses the load: busy only for that cycle.
    md_start_e = 1; md_div_e = 1; exc_m = 1;
    @(negedge clk);
    check("exc_md_busy_now", {31'd0, md_busy}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("exc_md_no_load", {31'd0, md_busy}, 32'd0);

    // Reload: div at t, mult at t+3, busy ends 6 cycles after the mult.
    @(posedge clk); #1;
    md_start_e = 1; md_div_e = 1;
    @(posedge clk); #1;
    md_start_e = 0;
    repeat (2) @(posedge clk);
    #1 md_start_e = 1; md_div_e = 0;
    @(posedge clk); #1;
    md_start_e = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reload_busy_t5", {31'd0, md_busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("reload_free_t6", {31'd0, md_busy}, 32'd0);

    // Reset mid-div with md_use_d held.
    @(posedge clk); #1;
    md_start_e = 1; md_div_e = 1; md_use_d = 1;
    @(posedge clk); #1;
    md_start_e = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("pre_reset_busy", {31'd0, md_busy}, 32'd1);
    @(posedge clk); #1;
    reset = 0;
    md_use_d = 0;
    @(negedge clk);
    check("reset_mid_div_busy", {31'd0, md_busy}, 32'd0);
    check("reset_mid_div_cnt", stall_cnt, 32'd0);

    // Wrap from all-ones on a single stall cycle.
    @(posedge clk); #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    rs_d = 5'd3; tuse_rs_d = TUSE_D; a3_e = 5'd3; tnew_e = 2'd1;
    @(negedge clk);
    check("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
    check("wrap_stall", {31'd0, stall_d}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    check("wrap_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    check("wrap_hold", stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
